// File: rtl/pluse_sync_multi.sv
// rtl/pluse_sync_multi.sv - multi-channel event synchroniser with edge select and pending-event counters
// Optional feature macro: PLUSE_SYNC_REG_OUT_EN (registers des_pluse, one extra cycle of latency).
module pluse_sync_multi #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                  des_clk,
  input  logic                  des_rst,
  input  logic [CH-1:0]         s_pluse,
  input  logic [2*CH-1:0]       mode,
  output logic [CH-1:0]         des_pluse,
  output logic [CH-1:0]         evt_valid,
  input  logic [CH-1:0]         evt_ready,
  output logic [CH*CNT_W-1:0]   evt_cnt,
  output logic [CH-1:0]         evt_ovf,
  input  logic [CH-1:0]         ovf_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Bit 0 of each chain is the first (metastable) stage.
  logic [CH-1:0][SYNC_STAGES-1:0] sync_q;
  logic [CH-1:0]                  hist_q;
  logic [CH-1:0]                  sync_last;
  logic [CH-1:0]                  evt_pulse;
  logic [CH-1:0]                  take;
  logic [CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [CH-1:0]                  valid_q, valid_d;
  logic [CH-1:0]                  ovf_q, ovf_d;

  always_ff @(posedge des_clk or posedge des_rst) begin
    if (des_rst) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], s_pluse[i]};
      end
      hist_q <= sync_last;
    end
  end

  always_comb begin
    sync_last = '0;
    for (int i = 0; i < CH; i++) begin
      sync_last[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  always_comb begin
    evt_pulse = '0;
    for (int i = 0; i < CH; i++) begin
      case (mode[2*i +: 2])
        2'b00:   evt_pulse[i] = sync_last[i] ^ hist_q[i];
        2'b01:   evt_pulse[i] = sync_last[i] & ~hist_q[i];
        2'b10:   evt_pulse[i] = ~sync_last[i] & hist_q[i];
        default: evt_pulse[i] = 1'b0;
      endcase
    end
  end

  // A take coinciding with an event cancels it, which also keeps a full counter from overflowing.
  always_comb begin
    take    = valid_q & evt_ready;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    valid_d = '0;
    for (int i = 0; i < CH; i++) begin
      if (evt_pulse[i] && !take[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else if (!evt_pulse[i] && take[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
      if (ovf_clr[i]) begin
        ovf_d[i] = 1'b0;
      end
      valid_d[i] = (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge des_clk or posedge des_rst) begin
    if (des_rst) begin
      cnt_q   <= '0;
      valid_q <= '0;
      ovf_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt_cnt   = cnt_q;
  assign evt_valid = valid_q;
  assign evt_ovf   = ovf_q;

`ifdef PLUSE_SYNC_REG_OUT_EN
  logic [CH-1:0] pluse_q;

  always_ff @(posedge des_clk or posedge des_rst) begin
    if (des_rst) begin
      pluse_q <= '0;
    end else begin
      pluse_q <= evt_pulse;
    end
  end

  assign des_pluse = pluse_q;
`else
  assign des_pluse = evt_pulse;
`endif

endmodule

// File: tb/tb_pluse_sync_multi.sv
// tb/tb_pluse_sync_multi.sv - randomized and directed bench for pluse_sync_multi against a sample-history model
module tb_pluse_sync_multi;

  localparam int CH    = 4;
  localparam int S     = 2;
  localparam int CNT_W = 4;
  localparam int MAX   = 15;
`ifdef PLUSE_SYNC_REG_OUT_EN
  localparam int REG = 1;
`else
  localparam int REG = 0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [CH-1:0]       s = '0;
  logic [CH-1:0]       ready = '0;
  logic [CH-1:0]       clr = '0;
  logic [2*CH-1:0]     mode = '0;
  logic [CH-1:0]       pulse, valid, ovf;
  logic [CH*CNT_W-1:0] cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pluse_sync_multi #(.CH(CH), .SYNC_STAGES(S), .CNT_W(CNT_W)) dut (
    .des_clk(clk), .des_rst(rst), .s_pluse(s), .mode(mode),
    .des_pluse(pulse), .evt_valid(valid), .evt_ready(ready),
    .evt_cnt(cnt), .evt_ovf(ovf), .ovf_clr(clr)
  );

  // Model: history of the input vector as sampled on each clock edge.
  logic [CH-1:0] smp[$];
  int            m_cnt[CH];
  bit            m_ovf[CH];
  bit            m_ev_q[CH];

  function automatic bit edge_of(int i);
    bit a, b;
    a = smp[smp.size()-S][i];
    b = smp[smp.size()-S-1][i];
    case (mode[2*i +: 2])
      2'b00:   return a ^ b;
      2'b01:   return a & !b;
      2'b10:   return !a & b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic m_reset();
    smp.delete();
    repeat (S+1) smp.push_back('0);
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0; m_ovf[i] = 0; m_ev_q[i] = 0;
    end
  endtask

  initial m_reset();

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reset();
    end else begin
      for (int i = 0; i < CH; i++) begin
        bit ev, tk;
        ev = edge_of(i);
        tk = (m_cnt[i] > 0) && ready[i];
        if (ev && !tk) begin
          if (m_cnt[i] == MAX) begin
            if (!clr[i]) m_ovf[i] = 1;
          end else begin
            m_cnt[i]++;
          end
        end else if (!ev && tk) begin
          m_cnt[i]--;
        end
        if (clr[i]) m_ovf[i] = 0;
        m_ev_q[i] = ev;
      end
      smp.push_back(s);
      if (smp.size() > S+2) void'(smp.pop_front());
    end
  end

  task automatic check(string nm, int ch, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s ch%0d: got %0d expected %0d at %0t", nm, ch, got, exp, $time);
  endtask

  function automatic int cnt_of(int i);
    return int'(cnt[i*CNT_W +: CNT_W]);
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < CH; i++) begin
      int exp_p;
      exp_p = (REG != 0) ? int'(m_ev_q[i]) : int'(edge_of(i));
      check("des_pluse", i, int'(pulse[i]), exp_p);
      check("evt_cnt",   i, cnt_of(i),      m_cnt[i]);
      check("evt_valid", i, int'(valid[i]), int'(m_cnt[i] != 0));
      check("evt_ovf",   i, int'(ovf[i]),   int'(m_ovf[i]));
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int hold[CH];
  int rate;

  initial begin
    tick(2);
    check("reset_cnt", 0, int'(cnt), 0);
    check("reset_valid", 0, int'(valid), 0);
    rst = 1'b0;

    // single rising toggle on ch0, mode any-edge
    s[0] = 1'b1;
    tick(2);
    check("t1_pulse_e2", 0, int'(pulse[0]), (REG != 0) ? 0 : 1);
    tick(1);
    check("t1_pulse_e3", 0, int'(pulse[0]), (REG != 0) ? 1 : 0);
    check("t1_cnt", 0, cnt_of(0), 1);
    check("t1_valid", 0, int'(valid[0]), 1);
    tick(2);

    // ch1 rising only, ch2 falling only
    mode = 8'b00_10_01_00;
    s[1] = 1'b1; s[2] = 1'b1;
    tick(4);
    s[1] = 1'b0; s[2] = 1'b0;
    tick(4);
    check("t2_cnt_rise", 1, cnt_of(1), 1);
    check("t2_cnt_fall", 2, cnt_of(2), 1);

    // ch3 disabled, then re-enabled
    mode[7:6] = 2'b11;
    repeat (3) begin
      s[3] = ~s[3];
      tick(4);
    end
    check("t3_cnt_dis", 3, cnt_of(3), 0);
    mode[7:6] = 2'b00;
    s[3] = ~s[3];
    tick(4);
    check("t3_cnt_en", 3, cnt_of(3), 1);

    // saturation and overflow on ch0
    ready[0] = 1'b1; tick(2); ready[0] = 1'b0;
    check("t4_drain", 0, cnt_of(0), 0);
    repeat (15) begin
      s[0] = ~s[0];
      tick(3);
    end
    check("t4_cnt15", 0, cnt_of(0), 15);
    check("t4_ovf0", 0, int'(ovf[0]), 0);
    s[0] = ~s[0];
    tick(3);
    check("t4_cnt_sat", 0, cnt_of(0), 15);
    check("t4_ovf1", 0, int'(ovf[0]), 1);
    clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
    check("t4_ovf_clr", 0, int'(ovf[0]), 0);
    s[0] = ~s[0];
    tick(2);
    ready[0] = 1'b1; tick(1); ready[0] = 1'b0;
    check("t4_take_cnt", 0, cnt_of(0), 15);
    check("t4_take_ovf", 0, int'(ovf[0]), 0);
    tick(2);

    // drain with a coincident event: 3,2,2,1,0
    ready[0] = 1'b1; tick(12); ready[0] = 1'b0;
    check("t5_cnt3", 0, cnt_of(0), 3);
    s[0] = ~s[0];
    tick(1);
    ready[0] = 1'b1;
    tick(1); check("t5_seq2a", 0, cnt_of(0), 2);
    tick(1); check("t5_seq2b", 0, cnt_of(0), 2);
    tick(1); check("t5_seq1", 0, cnt_of(0), 1);
    tick(1); check("t5_seq0", 0, cnt_of(0), 0);
    check("t5_valid0", 0, int'(valid[0]), 0);
    tick(1); check("t5_no_underflow", 0, cnt_of(0), 0);
    ready[0] = 1'b0;

    // asynchronous reset with pending events and an edge in flight
    s[0] = 1'b0; tick(4);
    ready[0] = 1'b1; tick(16); ready[0] = 1'b0;
    repeat (5) begin
      s[0] = ~s[0];
      tick(3);
    end
    check("t6_cnt5", 0, cnt_of(0), 5);
    s[0] = 1'b0;
    tick(1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_cnt", 0, int'(cnt), 0);
    check("t6_rst_valid", 0, int'(valid), 0);
    check("t6_rst_ovf", 0, int'(ovf), 0);
    check("t6_rst_pulse", 0, int'(pulse), 0);
    tick(2);
    rst = 1'b0;
    tick(6);
    check("t6_post_cnt", 0, int'(cnt), 0);

    // randomized traffic
    for (int i = 0; i < CH; i++) hold[i] = $urandom_range(S+1, 10);
    rate = 4;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 500 == 0) rate = $urandom_range(0, 7);
      for (int i = 0; i < CH; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          s[i] = ~s[i];
          hold[i] = $urandom_range(S+1, 10);
        end
        ready[i] = ($urandom_range(0, 7) < rate);
        clr[i]   = ($urandom_range(0, 31) == 0);
      end
      if ($urandom_range(0, 63) == 0) begin
        int c;
        c = $urandom_range(0, CH-1);
        mode[2*c +: 2] = 2'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 999) == 0);
      tick(1);
    end
    rst = 1'b0; ready = '0; clr = '0;
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
